// File: rtl/vericlock_pkg.sv
// Shared definitions for the clock/calendar setting path: state encoding, field indices
// and per-field digit blink masks.
package vericlock_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_SET_HOUR  = 3'd1,
      ST_SET_MIN   = 3'd2,
      ST_SET_SEC   = 3'd3,
      ST_SET_DAY   = 3'd4,
      ST_SET_MONTH = 3'd5,
      ST_SET_YEAR  = 3'd6
   } state_t;

   localparam int NUM_FIELDS = 6;

   localparam logic [2:0] FLD_SEC   = 3'd0;
   localparam logic [2:0] FLD_MIN   = 3'd1;
   localparam logic [2:0] FLD_HOUR  = 3'd2;
   localparam logic [2:0] FLD_DAY   = 3'd3;
   localparam logic [2:0] FLD_MONTH = 3'd4;
   localparam logic [2:0] FLD_YEAR  = 3'd5;

   localparam logic [7:0] MASK_HOUR_DAY  = 8'b0000_0011;
   localparam logic [7:0] MASK_MIN_MONTH = 8'b0000_1100;
   localparam logic [7:0] MASK_SEC       = 8'b0011_0000;
   localparam logic [7:0] MASK_YEAR      = 8'b1100_0000;

   function automatic logic [2:0] field_of(state_t s);
      case (s)
         ST_SET_HOUR:  field_of = FLD_HOUR;
         ST_SET_MIN:   field_of = FLD_MIN;
         ST_SET_DAY:   field_of = FLD_DAY;
         ST_SET_MONTH: field_of = FLD_MONTH;
         ST_SET_YEAR:  field_of = FLD_YEAR;
         default:      field_of = FLD_SEC;
      endcase
   endfunction

   function automatic logic [7:0] mask_of(state_t s);
      case (s)
         ST_SET_HOUR, ST_SET_DAY:  mask_of = MASK_HOUR_DAY;
         ST_SET_MIN, ST_SET_MONTH: mask_of = MASK_MIN_MONTH;
         ST_SET_SEC:               mask_of = MASK_SEC;
         ST_SET_YEAR:              mask_of = MASK_YEAR;
         default:                  mask_of = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge detector with hold-to-auto-repeat. Produces a combinational strobe request
// on the press edge, after HOLD_CYCLES of holding, then every REPEAT_CYCLES.
module btn_repeat #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 20_000_000,
   parameter int CNT_W         = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic clear,
   output logic rise,
   output logic strobe
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             prev;
   logic             blocked;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] rep_cnt;
   logic             holding;
   logic             hold_hit;
   logic             rep_hit;

   assign rise     = btn & ~prev;
   assign holding  = (hold_cnt == HOLD_FULL);
   assign hold_hit = btn & ~blocked & (hold_cnt == HOLD_LAST);
   assign rep_hit  = btn & ~blocked & holding & (rep_cnt == REP_LAST);
   assign strobe   = ~clear & ~blocked & (rise | hold_hit | rep_hit);

   // A clear while the button is down blocks it until released, so a held button
   // never carries over into whatever the clear switched to.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev     <= 1'b0;
         blocked  <= 1'b0;
         hold_cnt <= '0;
         rep_cnt  <= '0;
      end else begin
         prev    <= btn;
         blocked <= clear ? btn : (blocked & btn);
         if (clear || !btn || blocked) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
         end else if (!holding) begin
            hold_cnt <= hold_cnt + 1'b1;
         end else if (rep_hit) begin
            rep_cnt <= '0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_set_controller.sv
// Clock/calendar setting sequencer: field-select FSM, increment strobes with auto-repeat,
// display view steering, digit blink mask and inactivity timeout back to RUN.
module clock_set_controller
   import vericlock_pkg::*;
#(
   parameter int HOLD_CYCLES       = 50_000_000,
   parameter int REPEAT_CYCLES     = 20_000_000,
   parameter int BLINK_HALF_CYCLES = 25_000_000,
   parameter int TIMEOUT_SEC       = 10,
   parameter int CNT_W             = 26
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       view_sw,
   input  logic       tick_1Hz,
   output logic       inc_sec,
   output logic       inc_min,
   output logic       inc_hour,
   output logic       inc_day,
   output logic       inc_month,
   output logic       inc_year,
   output logic       run_tick_en,
   output logic       datetime,
   output logic [7:0] blink_mask,
   output logic       setting
);

   localparam int               TO_W       = $clog2(TIMEOUT_SEC + 1);
   localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_SEC);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_CYCLES - 1);

   state_t                state;
   state_t                state_next;
   logic                  mode_prev;
   logic                  mode_rise;
   logic                  up_rise;
   logic                  up_strobe;
   logic                  rpt_clear;
   logic                  in_set;
   logic                  timeout_hit;
   logic [TO_W-1:0]       to_cnt;
   logic [CNT_W-1:0]      blink_cnt;
   logic                  blink_phase;
   logic [NUM_FIELDS-1:0] inc_q;

   assign in_set      = (state != ST_RUN);
   assign mode_rise   = btn_mode & ~mode_prev;
   assign timeout_hit = in_set & ~mode_rise & (to_cnt == TO_LIMIT);
   // Mode presses and timeouts both discard any press or repeat of btn_up in flight.
   assign rpt_clear   = ~in_set | mode_rise | timeout_hit;

   btn_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_up_repeat (
      .clk    (clk_100MHz),
      .reset  (reset),
      .btn    (btn_up),
      .clear  (rpt_clear),
      .rise   (up_rise),
      .strobe (up_strobe)
   );

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state     <= ST_RUN;
         mode_prev <= 1'b0;
      end else begin
         state     <= state_next;
         mode_prev <= btn_mode;
      end
   end

   always_comb begin
      state_next = state;
      if (mode_rise) begin
         case (state)
            ST_RUN:       state_next = ST_SET_HOUR;
            ST_SET_HOUR:  state_next = ST_SET_MIN;
            ST_SET_MIN:   state_next = ST_SET_SEC;
            ST_SET_SEC:   state_next = ST_SET_DAY;
            ST_SET_DAY:   state_next = ST_SET_MONTH;
            ST_SET_MONTH: state_next = ST_SET_YEAR;
            default:      state_next = ST_RUN;
         endcase
      end else if (timeout_hit) begin
         state_next = ST_RUN;
      end
   end

   // Any button edge counts as activity and restarts the inactivity timeout.
   always_ff @(posedge clk_100MHz) begin
      if (reset || !in_set || mode_rise || up_rise) begin
         to_cnt <= '0;
      end else if (tick_1Hz && (to_cnt != TO_LIMIT)) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset || !in_set) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         inc_q <= '0;
      end else begin
         inc_q <= '0;
         if (up_strobe) begin
            inc_q[field_of(state)] <= 1'b1;
         end
      end
   end

   assign inc_sec   = inc_q[FLD_SEC];
   assign inc_min   = inc_q[FLD_MIN];
   assign inc_hour  = inc_q[FLD_HOUR];
   assign inc_day   = inc_q[FLD_DAY];
   assign inc_month = inc_q[FLD_MONTH];
   assign inc_year  = inc_q[FLD_YEAR];

   always_comb begin
      datetime = view_sw;
      case (state)
         ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC:   datetime = 1'b1;
         ST_SET_DAY, ST_SET_MONTH, ST_SET_YEAR: datetime = 1'b0;
         default:                               datetime = view_sw;
      endcase
   end

   assign run_tick_en = (state != ST_SET_SEC);
   assign setting     = in_set;
   assign blink_mask  = (blink_phase && !btn_up) ? mask_of(state) : 8'h00;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with shortened hold/repeat/blink/timeout
// parameters; expected values are hand-derived from the intended cycle timing.
module tb_clock_set_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode;
   logic       btn_up;
   logic       view_sw;
   logic       tick_1Hz;
   logic       inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year;
   logic       run_tick_en;
   logic       datetime;
   logic [7:0] blink_mask;
   logic       setting;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_inc[6];
   int day_q[$];

   clock_set_controller #(
      .HOLD_CYCLES       (20),
      .REPEAT_CYCLES     (5),
      .BLINK_HALF_CYCLES (4),
      .TIMEOUT_SEC       (3),
      .CNT_W             (26)
   ) dut (
      .clk_100MHz  (clk),
      .reset       (reset),
      .btn_mode    (btn_mode),
      .btn_up      (btn_up),
      .view_sw     (view_sw),
      .tick_1Hz    (tick_1Hz),
      .inc_sec     (inc_sec),
      .inc_min     (inc_min),
      .inc_hour    (inc_hour),
      .inc_day     (inc_day),
      .inc_month   (inc_month),
      .inc_year    (inc_year),
      .run_tick_en (run_tick_en),
      .datetime    (datetime),
      .blink_mask  (blink_mask),
      .setting     (setting)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobes are tallied mid-cycle so every pulse is seen exactly once.
   always @(negedge clk) begin
      if (inc_sec)   n_inc[0]++;
      if (inc_min)   n_inc[1]++;
      if (inc_hour)  n_inc[2]++;
      if (inc_day) begin
         n_inc[3]++;
         day_q.push_back(cyc);
      end
      if (inc_month) n_inc[4]++;
      if (inc_year)  n_inc[5]++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic m, input logic u, input logic t);
      btn_mode = m;
      btn_up   = u;
      tick_1Hz = t;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clearCounts();
      foreach (n_inc[i]) n_inc[i] = 0;
      day_q.delete();
   endtask

   function automatic int totalInc();
      int s = 0;
      foreach (n_inc[i]) s += n_inc[i];
      return s;
   endfunction

   task automatic modePulse();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitMask(output logic [7:0] m);
      m = 8'h00;
      for (int i = 0; i < 12 && m == 8'h00; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         m = blink_mask;
      end
   endtask

   initial begin
      logic [7:0] m;
      logic [7:0] prev;
      logic       found;
      int         c0;
      int         offs[5];
      int         obs;

      offs = '{1, 20, 25, 30, 35};
      foreach (n_inc[i]) n_inc[i] = 0;
      reset = 1'b1; btn_mode = 1'b0; btn_up = 1'b1; view_sw = 1'b1; tick_1Hz = 1'b0;

      // Reset with btn_up held
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("reset_setting", setting, 1'b0);
      checkOutput("reset_run_tick_en", run_tick_en, 1'b1);
      checkOutput("reset_blink_mask", blink_mask, 8'h00);
      checkOutput("reset_datetime_view1", datetime, 1'b1);
      reset = 1'b0;
      clearCounts();
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("reset_held_no_strobe", totalInc(), 0);
      checkOutput("run_setting", setting, 1'b0);
      view_sw = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("run_datetime_view0", datetime, 1'b0);

      // Two mode presses then a 3-cycle btn_up press in SET_MIN
      modePulse();
      modePulse();
      checkOutput("min_setting", setting, 1'b1);
      checkOutput("min_datetime", datetime, 1'b1);
      clearCounts();
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("inc_min_at_rise_plus1", inc_min, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("inc_min_single_cycle", inc_min, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("inc_min_count", n_inc[1], 1);
      checkOutput("min_total_inc", totalInc(), 1);

      // SET_SEC: seconds frozen, blink alternates every 4 cycles
      modePulse();
      checkOutput("sec_run_tick_en", run_tick_en, 1'b0);
      checkOutput("sec_datetime", datetime, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         prev = blink_mask;
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (prev == 8'h00 && blink_mask == 8'h30) found = 1'b1;
      end
      checkOutput("sec_blink_sync", found, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("sec_blink_k%0d", k), blink_mask,
                     (k < 4 || k == 8) ? 8'h30 : 8'h00);
      end

      // SET_DAY: hold btn_up for auto-repeat, release before the next repeat
      modePulse();
      checkOutput("day_datetime", datetime, 1'b0);
      checkOutput("day_run_tick_en", run_tick_en, 1'b1);
      clearCounts();
      c0 = cyc;
      repeat (38) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("day_strobe_count", day_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         obs = (i < day_q.size()) ? day_q[i] - c0 : -1;
         checkOutput($sformatf("day_strobe%0d_offset", i), obs, offs[i]);
      end
      checkOutput("day_total_inc", totalInc(), 5);

      // SET_MONTH: mode and up rise together -> SET_YEAR, no strobes even when held
      modePulse();
      checkOutput("month_datetime", datetime, 1'b0);
      clearCounts();
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (24) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("collide_inc_month", n_inc[4], 0);
      checkOutput("collide_inc_year", n_inc[5], 0);
      checkOutput("collide_total_inc", totalInc(), 0);
      waitMask(m);
      checkOutput("year_mask", m, 8'hC0);

      // Back to RUN, then timeout from SET_HOUR
      modePulse();
      checkOutput("year_to_run", setting, 1'b0);
      checkOutput("run_blink_zero", blink_mask, 8'h00);
      view_sw = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("run_datetime_view1", datetime, 1'b1);
      view_sw = 1'b0;
      modePulse();
      checkOutput("hour_datetime", datetime, 1'b1);
      waitMask(m);
      checkOutput("hour_mask", m, 8'h03);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("hour_two_ticks", setting, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hour_third_tick", setting, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("timeout_to_run", setting, 1'b0);
      checkOutput("timeout_blink_zero", blink_mask, 8'h00);
      checkOutput("timeout_run_tick_en", run_tick_en, 1'b1);
      checkOutput("timeout_datetime_view0", datetime, 1'b0);
      view_sw = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("timeout_datetime_view1", datetime, 1'b1);

      // Reset mid-SET with btn_up held: held button stays inert until re-pressed
      modePulse();
      reset = 1'b1;
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("midset_reset_run", setting, 1'b0);
      reset = 1'b0;
      clearCounts();
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (25) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("held_after_reset_setting", setting, 1'b1);
      checkOutput("held_after_reset_no_strobe", totalInc(), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("repress_inc_hour", inc_hour, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("repress_total_inc", totalInc(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
